// File: rtl/param_systolic_array.sv
// Weight-stationary systolic matrix-vector engine: y_c = sum_r w[r][c]*x_r.
// Inputs are skewed by row, x/valid travel right, partial sums travel down.
module param_systolic_array #(
  parameter int ROWS = 5,
  parameter int COLS = 5,
  parameter int DW   = 8,
  parameter int AW   = 16,
  parameter int SAT  = 0,
  localparam int NPE = ROWS * COLS,
  localparam int WAW = (NPE > 1) ? $clog2(NPE) : 1
) (
  input  logic                 clk,
  input  logic                 clear_n,
  input  logic                 w_valid,
  output logic                 w_ready,
  input  logic [WAW-1:0]       w_addr,
  input  logic [DW-1:0]        w_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_last,
  input  logic [ROWS*DW-1:0]   in_data,
  output logic [COLS-1:0]      out_valid,
  output logic [COLS*AW-1:0]   out_data,
  output logic                 busy
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, ready depends only on state.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int CW         = $clog2(ROWS + COLS + 1);
  localparam int DRAIN_LAST = ROWS + COLS - 2;

  state_t             state;
  state_t             state_nxt;
  logic [CW-1:0]      drain_cnt;
  logic               beat_acc;
  logic               w_acc;
  logic               w_hit;
  logic               beat_tag;
  logic [WAW-1:0]     old_addr;
  logic [DW-1:0]      old_data;
  logic [DW-1:0]      wgt_rd;
  logic [NPE*DW-1:0]  rd_terms;
  logic [DW-1:0]      row_x [ROWS];
  logic               row_v [ROWS];
  logic               row_t [ROWS];

  assign beat_acc = in_valid && in_ready;
  assign w_acc    = w_valid && w_ready;
  assign w_hit    = w_acc && (int'(w_addr) < NPE);
  // A beat taking the same IDLE edge as a weight write must still see the old weight.
  assign beat_tag = beat_acc && w_hit;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, RUN: if (beat_acc) state_nxt = in_last ? DRAIN : RUN;
      DRAIN:     if (drain_cnt == CW'(DRAIN_LAST)) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_ready  = (state == IDLE);
    in_ready = (state != DRAIN);
    busy     = (state != IDLE);
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n)                                  drain_cnt <= '0;
    else if (state == DRAIN && state_nxt == DRAIN) drain_cnt <= drain_cnt + 1'b1;
    else                                           drain_cnt <= '0;
  end

  // ---------------------------------------------------------------- old-weight capture
  always_comb begin
    wgt_rd = '0;
    for (int i = 0; i < NPE; i++) wgt_rd = wgt_rd | rd_terms[i*DW +: DW];
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      old_addr <= '0;
      old_data <= '0;
    end else if (beat_tag) begin
      old_addr <= w_addr;
      old_data <= wgt_rd;
    end
  end

  // ---------------------------------------------------------------- input skew
  for (genvar r = 0; r < ROWS; r++) begin : g_skew
    logic [DW-1:0] x_in;
    logic          v_in;
    logic          t_in;

    assign x_in = beat_acc ? in_data[r*DW +: DW] : '0;
    assign v_in = beat_acc;
    assign t_in = beat_tag;

    if (r == 0) begin : g_dly
      assign row_x[r] = x_in;
      assign row_v[r] = v_in;
      assign row_t[r] = t_in;
    end else begin : g_dly
      logic [DW-1:0] sx [r];
      logic          sv [r];
      logic          st [r];

      always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
          for (int k = 0; k < r; k++) begin
            sx[k] <= '0;
            sv[k] <= 1'b0;
            st[k] <= 1'b0;
          end
        end else begin
          sx[0] <= x_in;
          sv[0] <= v_in;
          st[0] <= t_in;
          for (int k = 1; k < r; k++) begin
            sx[k] <= sx[k-1];
            sv[k] <= sv[k-1];
            st[k] <= st[k-1];
          end
        end
      end

      assign row_x[r] = sx[r-1];
      assign row_v[r] = sv[r-1];
      assign row_t[r] = st[r-1];
    end
  end

  // ---------------------------------------------------------------- PE grid
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam int IDX = r * COLS + c;

      logic [DW-1:0]   w_q;
      logic [DW-1:0]   w_use;
      logic [DW-1:0]   x_i;
      logic            v_i;
      logic            t_i;
      logic [AW-1:0]   s_i;
      logic [AW-1:0]   s_q;
      logic [AW-1:0]   s_nxt;
      logic [2*DW-1:0] prod;
      logic [AW:0]     sum;

      if (c == 0) begin : g_src
        assign x_i = row_x[r];
        assign v_i = row_v[r];
        assign t_i = row_t[r];
      end else begin : g_src
        assign x_i = g_row[r].g_col[c-1].g_fwd.x_q;
        assign v_i = g_row[r].g_col[c-1].g_vld.v_q;
        assign t_i = g_row[r].g_col[c-1].g_fwd.t_q;
      end

      if (r == 0) begin : g_up
        assign s_i = '0;
      end else begin : g_up
        assign s_i = g_row[r-1].g_col[c].s_q;
      end

      assign w_use = (t_i && old_addr == WAW'(IDX)) ? old_data : w_q;
      assign prod  = w_use * x_i;
      // Products are assumed to fit in AW bits (AW >= 2*DW).
      assign sum   = {1'b0, s_i} + (AW+1)'(prod);
      assign s_nxt = (SAT != 0 && sum[AW]) ? {AW{1'b1}} : sum[AW-1:0];

      assign rd_terms[IDX*DW +: DW] = (w_addr == WAW'(IDX)) ? w_q : '0;

      always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
          w_q <= DW'(r + 1);
          s_q <= '0;
        end else begin
          if (w_hit && w_addr == WAW'(IDX)) w_q <= w_data;
          s_q <= s_nxt;
        end
      end

      if (c < COLS - 1) begin : g_fwd
        logic [DW-1:0] x_q;
        logic          t_q;
        always_ff @(posedge clk or negedge clear_n) begin
          if (!clear_n) begin
            x_q <= '0;
            t_q <= 1'b0;
          end else begin
            x_q <= x_i;
            t_q <= t_i;
          end
        end
      end

      if (c < COLS - 1 || r == ROWS - 1) begin : g_vld
        logic v_q;
        always_ff @(posedge clk or negedge clear_n) begin
          if (!clear_n) v_q <= 1'b0;
          else          v_q <= v_i;
        end
      end

      if (r == ROWS - 1) begin : g_out
        assign out_valid[c]          = g_vld.v_q;
        assign out_data[c*AW +: AW]  = s_q;
      end
    end
  end

endmodule

// File: tb/tb_param_systolic_array.sv
// Directed bench for param_systolic_array (5x5, DW=8, AW=16), wrapping and
// saturating instances driven in parallel; results go through a timed scoreboard.
module tb_param_systolic_array;

  localparam int ROWS = 5;
  localparam int COLS = 5;
  localparam int DW   = 8;
  localparam int AW   = 16;

  logic                clk = 1'b0;
  logic                clear_n;
  logic                w_valid;
  logic [4:0]          w_addr;
  logic [DW-1:0]       w_data;
  logic                in_valid;
  logic                in_last;
  logic [ROWS*DW-1:0]  in_data;

  logic                w_ready0, in_ready0, busy0;
  logic [COLS-1:0]     out_valid0;
  logic [COLS*AW-1:0]  out_data0;
  logic                w_ready1, in_ready1, busy1;
  logic [COLS-1:0]     out_valid1;
  logic [COLS*AW-1:0]  out_data1;

  param_systolic_array #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .AW(AW), .SAT(0)) dut0 (
    .clk(clk), .clear_n(clear_n), .w_valid(w_valid), .w_ready(w_ready0),
    .w_addr(w_addr), .w_data(w_data), .in_valid(in_valid), .in_ready(in_ready0),
    .in_last(in_last), .in_data(in_data), .out_valid(out_valid0),
    .out_data(out_data0), .busy(busy0)
  );

  param_systolic_array #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .AW(AW), .SAT(1)) dut1 (
    .clk(clk), .clear_n(clear_n), .w_valid(w_valid), .w_ready(w_ready1),
    .w_addr(w_addr), .w_data(w_data), .in_valid(in_valid), .in_ready(in_ready1),
    .in_last(in_last), .in_data(in_data), .out_valid(out_valid1),
    .out_data(out_data1), .busy(busy1)
  );

  // ---------------------------------------------------------------- clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------------------------------------------------------- checking
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Scoreboard entries are {cycle, column, value}.
  logic [39:0] exp0_q[$];
  logic [39:0] exp1_q[$];
  logic [39:0] obs0_q[$];
  logic [39:0] obs1_q[$];

  function automatic logic [39:0] ev(input int t, input int c, input int y);
    return {t[15:0], c[7:0], y[15:0]};
  endfunction

  always @(negedge clk) begin
    for (int c = 0; c < COLS; c++) begin
      if (out_valid0[c]) obs0_q.push_back(ev(cyc, c, int'(out_data0[c*AW +: AW])));
      if (out_valid1[c]) obs1_q.push_back(ev(cyc, c, int'(out_data1[c*AW +: AW])));
    end
  end

  task automatic exp_col(input int t, input int c, input int y0, input int y1);
    exp0_q.push_back(ev(t + ROWS + c, c, y0));
    exp1_q.push_back(ev(t + ROWS + c, c, y1));
  endtask

  task automatic exp_all(input int t, input int y);
    for (int c = 0; c < COLS; c++) exp_col(t, c, y, y);
  endtask

  task automatic sb_compare(input string tag);
    exp0_q.sort();
    exp1_q.sort();
    check({tag, "_count0"}, 64'(obs0_q.size()), 64'(exp0_q.size()));
    check({tag, "_count1"}, 64'(obs1_q.size()), 64'(exp1_q.size()));
    for (int i = 0; i < exp0_q.size() && i < obs0_q.size(); i++)
      check({tag, "_ev0"}, 64'(obs0_q[i]), 64'(exp0_q[i]));
    for (int i = 0; i < exp1_q.size() && i < obs1_q.size(); i++)
      check({tag, "_ev1"}, 64'(obs1_q[i]), 64'(exp1_q[i]));
    exp0_q.delete(); exp1_q.delete(); obs0_q.delete(); obs1_q.delete();
  endtask

  // ---------------------------------------------------------------- drivers
  function automatic logic [ROWS*DW-1:0] vec(input int a, input int b, input int c,
                                             input int d, input int e);
    return {e[7:0], d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction

  task automatic beat(input logic v, input logic last, input logic [ROWS*DW-1:0] d);
    in_valid = v;
    in_last  = last;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  task automatic wr(input int a, input int d);
    w_valid = 1'b1;
    w_addr  = a[4:0];
    w_data  = d[7:0];
    @(negedge clk);
    check("w_ready_idle", 64'(w_ready0), 64'd1);
    @(posedge clk); #1;
    w_valid = 1'b0;
  endtask

  task automatic wait_idle(input int t0, input int drop, input string tag);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!busy0) break;
    end
    check(tag, 64'(cyc - t0), 64'(drop));
    check({tag, "_sat"}, 64'(busy1), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    clear_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    clear_n = 1'b1;
    @(posedge clk); #1;
    obs0_q.delete(); obs1_q.delete();
  endtask

  // ---------------------------------------------------------------- stimulus
  int t0;
  int t1;

  initial begin
    clear_n  = 1'b0;
    w_valid  = 1'b0;
    w_addr   = '0;
    w_data   = '0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid0), 64'd0);
    check("rst_out_data",  64'(out_data0), 64'd0);
    check("rst_busy",      64'(busy0), 64'd0);
    check("rst_in_ready",  64'(in_ready0), 64'd1);
    check("rst_w_ready",   64'(w_ready0), 64'd1);
    clear_n = 1'b1;
    @(posedge clk); #1;

    // Default weights r+1, ones vector
    t0 = cyc;
    beat(1'b1, 1'b1, vec(1, 1, 1, 1, 1));
    exp_all(t0, 15);
    @(negedge clk);
    check("drain_in_ready", 64'(in_ready0), 64'd0);
    check("drain_w_ready",  64'(w_ready0), 64'd0);
    check("drain_busy",     64'(busy0), 64'd1);
    wait_idle(t0, 10, "t1_busy_drop");
    sb_compare("t1");

    // Single weight load at row 2 col 3
    wr(13, 10);
    t0 = cyc;
    beat(1'b1, 1'b1, vec(0, 0, 3, 0, 0));
    for (int c = 0; c < COLS; c++) exp_col(t0, c, (c == 3) ? 30 : 9, (c == 3) ? 30 : 9);
    wait_idle(t0, 10, "t2_busy_drop");
    sb_compare("t2");

    // Overflow: wrap vs clamp
    do_reset();
    for (int i = 0; i < ROWS * COLS; i++) wr(i, 255);
    t0 = cyc;
    beat(1'b1, 1'b1, vec(255, 255, 255, 255, 255));
    for (int c = 0; c < COLS; c++) exp_col(t0, c, 62981, 65535);
    wait_idle(t0, 10, "t3_busy_drop");
    sb_compare("t3");

    // Streaming with a bubble
    do_reset();
    t0 = cyc;
    beat(1'b1, 1'b0, vec(1, 2, 3, 4, 5));
    beat(1'b1, 1'b0, vec(10, 0, 0, 0, 0));
    beat(1'b0, 1'b0, vec(7, 7, 7, 7, 7));
    beat(1'b1, 1'b1, vec(1, 1, 1, 1, 1));
    exp_all(t0, 55);
    exp_all(t0 + 1, 10);
    exp_all(t0 + 3, 15);
    @(negedge clk);
    check("t4_drain_in_ready", 64'(in_ready0), 64'd0);
    wait_idle(t0, 13, "t4_busy_drop");
    sb_compare("t4");

    // Weight write refused while busy
    t0 = cyc;
    beat(1'b1, 1'b0, vec(1, 1, 1, 1, 1));
    w_valid  = 1'b1;
    w_addr   = 5'd0;
    w_data   = 8'd99;
    in_valid = 1'b1;
    in_last  = 1'b1;
    in_data  = vec(2, 0, 0, 0, 0);
    @(negedge clk);
    check("t5_w_ready_run", 64'(w_ready0), 64'd0);
    check("t5_busy_run",    64'(busy0), 64'd1);
    @(posedge clk); #1;
    w_valid  = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    exp_all(t0, 15);
    exp_all(t0 + 1, 2);
    wait_idle(t0, 11, "t5_busy_drop");
    t1 = cyc;
    beat(1'b1, 1'b1, vec(1, 0, 0, 0, 0));
    exp_all(t1, 1);
    wait_idle(t1, 10, "t5b_busy_drop");
    sb_compare("t5");

    // Reset in the middle of RUN
    do_reset();
    wr(0, 50);
    t0 = cyc;
    beat(1'b1, 1'b0, vec(1, 1, 1, 1, 1));
    beat(1'b1, 1'b0, vec(2, 2, 2, 2, 2));
    @(posedge clk); #1;
    clear_n = 1'b0;
    #1;
    check("t6_async_busy",      64'(busy0), 64'd0);
    check("t6_async_out_valid", 64'(out_valid0), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    clear_n = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    check("t6_no_results0", 64'(obs0_q.size()), 64'd0);
    check("t6_no_results1", 64'(obs1_q.size()), 64'd0);
    check("t6_idle_w_ready", 64'(w_ready0), 64'd1);
    check("t6_idle_busy",    64'(busy0), 64'd0);
    obs0_q.delete(); obs1_q.delete();
    t1 = cyc;
    beat(1'b1, 1'b1, vec(1, 0, 0, 0, 0));
    exp_all(t1, 1);
    wait_idle(t1, 10, "t6_busy_drop");
    sb_compare("t6");

    // Write and beat on the same edge, then out-of-range writes
    do_reset();
    t0 = cyc;
    w_valid = 1'b1;
    w_addr  = 5'd5;
    w_data  = 8'd7;
    beat(1'b1, 1'b1, vec(0, 1, 0, 0, 0));
    w_valid = 1'b0;
    exp_all(t0, 2);
    wait_idle(t0, 10, "t7_busy_drop");
    wr(25, 0);
    wr(31, 0);
    t1 = cyc;
    beat(1'b1, 1'b1, vec(0, 1, 0, 0, 0));
    for (int c = 0; c < COLS; c++) exp_col(t1, c, (c == 0) ? 7 : 2, (c == 0) ? 7 : 2);
    wait_idle(t1, 10, "t7b_busy_drop");
    sb_compare("t7");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/param_systolic_array.md
PARAM_SYSTOLIC_ARRAY -- requirements
Module: param_systolic_array

Interface
REQ-001 SHALL have parameter ROWS, default 5: number of PE rows (input vector length).
REQ-002 SHALL have parameter COLS, default 5: number of PE columns (output vector length).
REQ-003 SHALL have parameter DW, default 8: unsigned data and weight width.
REQ-004 SHALL have parameter AW, default 16: partial-sum and output width.
REQ-005 SHALL have parameter SAT, default 0: 0 means accumulation wraps modulo 2^AW; 1 means accumulation clamps at 2^AW-1.
REQ-006 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-007 SHALL have port clear_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port w_valid, input, 1 bit: weight-write request.
REQ-009 SHALL have port w_ready, output, 1 bit: weight write accepted; high only in IDLE.
REQ-010 SHALL have port w_addr, input, clog2(ROWS*COLS) bits: PE index r*COLS+c.
REQ-011 SHALL have port w_data, input, DW bits: weight value.
REQ-012 SHALL have port in_valid, input, 1 bit: input beat present.
REQ-013 SHALL have port in_ready, output, 1 bit: beat accepted; high in IDLE and RUN.
REQ-014 SHALL have port in_last, input, 1 bit: final beat of the operation.
REQ-015 SHALL have port in_data, input, ROWS*DW bits: x_r occupies bits [r*DW +: DW].
REQ-016 SHALL have port out_valid, output, COLS bits: per-column result valid.
REQ-017 SHALL have port out_data, output, COLS*AW bits: y_c occupies bits [c*AW +: AW].
REQ-018 SHALL have port busy, output, 1 bit: high when state is not IDLE.

Function
REQ-019 SHALL compute y_c = sum over r of w[r][c]*x_r for each accepted beat (matrix-vector product); each product is zero-extended to AW bits.
REQ-020 SHALL be built as a ROWS x COLS grid of registered PEs: x and a valid bit pass right one column per cycle; partial sums pass down one row per cycle; row 0 starts from a partial sum of 0.
REQ-021 SHALL delay row r input internally by r cycles (input skew), so the caller presents all x_r aligned in one beat.
REQ-022 SHALL assert out_valid[c] with y_c exactly ROWS+c cycles after the cycle in which the beat is accepted (beat accepted in cycle 0 gives column 0 in cycle ROWS).
REQ-023 SHALL, with SAT=1, clamp every PE addition at 2^AW-1; with SAT=0, truncate every PE addition to AW bits.
REQ-024 SHALL accept a beat in a cycle where in_valid and in_ready are both high; cycles with in_valid low are bubbles and appear as out_valid low at the same relative positions.
REQ-025 SHALL implement an FSM with states IDLE, RUN and DRAIN.
REQ-026 IDLE: an accepted beat with in_last=0 SHALL move to RUN; an accepted beat with in_last=1 SHALL move to DRAIN.
REQ-027 RUN: an accepted beat with in_last=1 SHALL move to DRAIN; w_ready SHALL be 0 in RUN.
REQ-028 DRAIN: in_ready and w_ready SHALL be 0; a counter SHALL count ROWS+COLS-1 cycles, then return to IDLE in the cycle after the last column's result.
REQ-029 SHALL write w_data into w[w_addr] on a cycle with w_valid and w_ready both high; an out-of-range w_addr SHALL be ignored.
REQ-030 SHALL, when a weight write and a beat are accepted in the same IDLE cycle, perform both: the beat uses the old weights and the new weight applies from the next cycle.
REQ-031 SHALL keep weights unchanged while busy; requests then are not accepted (w_ready=0).

Reset
REQ-032 clear_n low SHALL asynchronously force: state IDLE, drain counter 0, all PE valid bits and partial sums 0, skew registers 0, out_valid 0, out_data 0, busy 0.
REQ-033 Reset SHALL set weight w[r][c] to (r+1) truncated to DW bits, which gives the legacy fixed-weight behaviour.
REQ-034 Reset asserted mid-operation SHALL discard all in-flight beats; none of their results appear after release.
REQ-035 SHALL, after clear_n deasserts, accept beats and weights from the first rising edge.

Verification (ROWS=COLS=5, DW=8, AW=16)
REQ-036 Default weights: one beat x=[1,1,1,1,1] with in_last=1 in cycle 0 -> out_valid[c]=1 with y_c=15 in cycle 5+c; busy=0 from cycle 10.
REQ-037 Weight load: write w_addr=13 (row 2, col 3) with 10, then x=[0,0,3,0,0] -> y_3=30; all other columns give y=9.
REQ-038 Overflow: all weights 255 and x all 255 -> SAT=0 gives y=62981; SAT=1 gives y=65535.
REQ-039 Streaming: beats A,B,bubble,C (C last) with default weights -> each column outputs A,B,gap,C in order at the same spacing; in_ready=0 during DRAIN.
REQ-040 Reset mid-RUN: clear_n pulsed low in cycle 3 after two beats -> out_valid is 0 from the assertion onward and never pulses for those beats; weights return to r+1; state is IDLE.
REQ-041 Busy write: w_valid=1 during RUN -> w_ready=0 and the weight is unchanged; the next operation's results match the old weights.
